ddr3_burst_agen: RTL and testbench
==================================

DDR3_BURST_AGEN -- requirements
Module: ddr3_burst_agen

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of every data port.
REQ-002 Parameter ADDR_WIDTH, default 36, SHALL set the width of the RAM address ports; values below 35 are unsupported.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  burst command present.
REQ-006 cmd_ready  output  1  command accepted on this edge when both cmd_valid and cmd_ready are high.
REQ-007 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_bank  input  3  bank; cmd_row  input  13  row; cmd_col  input  10  starting column.
REQ-009 cmd_bc4  input  1  1 = burst-chop 4 beats, 0 = BL8 (8 beats).
REQ-010 cmd_bt  input  1  burst type: 0 = sequential, 1 = interleaved.
REQ-011 wr_data  input  DATA_WIDTH, wr_valid  input  1, wr_ready  output  1  write beat handshake.
REQ-012 ram_di  output  DATA_WIDTH, ram_we  output  1, ram_write_addr  output  ADDR_WIDTH, ram_read_addr  output  ADDR_WIDTH  drive the dual-port burst RAM.
REQ-013 ram_do  input  DATA_WIDTH  RAM read data, valid the cycle after the RAM captures an address with ram_we low.
REQ-014 rd_data  output  DATA_WIDTH, rd_valid  output  1  read beats to the consumer; no backpressure.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, DRAIN; cmd_ready SHALL equal (state==IDLE).
REQ-017 On command acceptance, bank, row, col, bc4, bt SHALL be latched and beat counter i cleared; next state WRITE if cmd_write, else READ.
REQ-018 Beat count N SHALL be 4 if bc4 else 8.
REQ-019 Beat column SHALL be {col[9:3], c[2:0]}, sequential: c = {col[2]^i[2], col[1:0]+i[1:0]} (2-bit wrap); interleaved: c = col[2:0]^i[2:0]; bc4 forces i[2]=0.
REQ-020 RAM address SHALL be: bits [34:32] bank, [28:16] row, [9:0] beat column, all other bits zero.
REQ-021 WRITE: wr_ready high; each wr_valid&wr_ready edge SHALL register ram_we=1, ram_di=wr_data, ram_write_addr=beat address, and increment i; edges without wr_valid SHALL register ram_we=0 (bubble).
REQ-022 WRITE: the edge accepting beat N-1 SHALL move to IDLE; that beat's ram_we pulse occurs in the following cycle.
REQ-023 READ: ram_we SHALL stay 0; ram_read_addr for beat 0 SHALL be registered on the acceptance edge, and beat i+1 on each following edge, no bubbles.
REQ-024 READ: the edge registering beat N-1 SHALL move to DRAIN; DRAIN SHALL last exactly one cycle, then IDLE.
REQ-025 rd_valid SHALL be a register set on each edge at which the RAM captures a READ-issued address; rd_data SHALL equal ram_do; beat k of a read accepted at edge E0 is valid in the cycle after edge E0+1+k.
REQ-026 A read accepted directly after a write SHALL never see ram_we high on the edge its first address is captured.
REQ-027 wr_valid outside WRITE SHALL be ignored; cmd_valid outside IDLE SHALL not be accepted.

Reset
REQ-028 rst_n low SHALL force IDLE, i=0, and all outputs low/zero except cmd_ready, which SHALL be 1 after reset release.
REQ-029 Reset mid-burst SHALL abandon the burst immediately; no further ram_we or rd_valid SHALL be produced for it.

Configuration
REQ-030 Macro DDR3_BURST_INTERLEAVE_EN defined: cmd_bt SHALL select ordering per REQ-019.
REQ-031 Macro DDR3_BURST_INTERLEAVE_EN undefined: cmd_bt port SHALL remain but be ignored; ordering SHALL always be sequential.

Verification
REQ-032 Reset: rst_n low mid-WRITE beat 3 -> ram_we=0, wr_ready=0, busy=0, cmd_ready=1 after release.
REQ-033 BL8 sequential write bank=5 row=0x1ABC col=0x3F5, data 0x10..0x17 -> columns 0x3F5,0x3F6,0x3F7,0x3F4,0x3F1,0x3F2,0x3F3,0x3F0; ram_write_addr bits[34:32]=5, [28:16]=0x1ABC.
REQ-034 Same address read back -> rd_valid 8 consecutive cycles starting cycle after edge E0+1, rd_data 0x10..0x17 in order.
REQ-035 BC4 interleaved read col=0x006 (macro defined) -> columns 0x006,0x007,0x004,0x005, exactly 4 rd_valid pulses.
REQ-036 Write with wr_valid low on beats 2 and 5 -> 8 ram_we pulses, 2 bubbles, data/address order unchanged.
REQ-037 Write immediately followed by read of same burst -> no ram_we overlap with read capture; read data equals written data.

Source files
------------

// File: rtl/ddr3_burst_agen.sv
// DDR3 burst address generator: expands one burst command into per-beat RAM addresses.
// Optional macro DDR3_BURST_INTERLEAVE_EN enables interleaved ordering through cmd_bt.
module ddr3_burst_agen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_bank,
    input  logic [12:0]           cmd_row,
    input  logic [9:0]            cmd_col,
    input  logic                  cmd_bc4,
    input  logic                  cmd_bt,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

`ifdef DDR3_BURST_INTERLEAVE_EN
    localparam logic ILV_EN = 1'b1;
`else
    localparam logic ILV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [2:0]              bank_r;
    logic [12:0]             row_r;
    logic [9:0]              col_r;
    logic                    bc4_r;
    logic                    bt_r;
    logic [2:0]              beat_r;
    logic                    accept_s;
    logic                    wr_beat_s;
    logic                    bt_sel_s;
    logic [2:0]              rd_idx_s;
    logic [2:0]              last_idx_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic [ADDR_WIDTH-1:0]   rd_addr_s;
    logic                    ram_we_r;
    logic [DATA_WIDTH-1:0]   ram_di_r;
    logic [ADDR_WIDTH-1:0]   ram_write_addr_r;
    logic [ADDR_WIDTH-1:0]   ram_read_addr_r;
    logic                    rd_issue_r;
    logic                    rd_valid_r;

    // Column of beat idx within the 8-column block; burst chop never reaches the upper half.
    function automatic logic [9:0] beat_col(input logic [9:0] col, input logic [2:0] idx,
                                            input logic bc4, input logic bt);
        logic [2:0] i_eff;
        logic [2:0] c;
        i_eff = {idx[2] & ~bc4, idx[1:0]};
        if (bt) begin
            c = col[2:0] ^ i_eff;
        end else begin
            c = {col[2] ^ i_eff[2], col[1:0] + i_eff[1:0]};
        end
        return {col[9:3], c};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [2:0] bank,
                                                       input logic [12:0] row,
                                                       input logic [9:0] col);
        logic [ADDR_WIDTH-1:0] a;
        a        = '0;
        a[34:32] = bank;
        a[28:16] = row;
        a[9:0]   = col;
        return a;
    endfunction

    // Next-state logic and per-beat address selection.
    always_comb begin
        bt_sel_s   = cmd_bt & ILV_EN;
        accept_s   = cmd_valid && (state_r == IDLE);
        wr_beat_s  = wr_valid && (state_r == WRITE);
        rd_idx_s   = beat_r + 3'd1;
        last_idx_s = bc4_r ? 3'd3 : 3'd7;
        wr_addr_s  = beat_addr(bank_r, row_r, beat_col(col_r, beat_r, bc4_r, bt_r));
        if (state_r == IDLE) begin
            rd_addr_s = beat_addr(cmd_bank, cmd_row, beat_col(cmd_col, 3'd0, cmd_bc4, bt_sel_s));
        end else begin
            rd_addr_s = beat_addr(bank_r, row_r, beat_col(col_r, rd_idx_s, bc4_r, bt_r));
        end
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = cmd_write ? WRITE : READ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WRITE: begin
                if (wr_beat_s && (beat_r == last_idx_s)) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            READ: begin
                if (rd_idx_s == last_idx_s) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = READ;
                end
            end
            DRAIN:   state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Command latch and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= 3'd0;
            row_r  <= 13'd0;
            col_r  <= 10'd0;
            bc4_r  <= 1'b0;
            bt_r   <= 1'b0;
            beat_r <= 3'd0;
        end else if (accept_s) begin
            bank_r <= cmd_bank;
            row_r  <= cmd_row;
            col_r  <= cmd_col;
            bc4_r  <= cmd_bc4;
            bt_r   <= bt_sel_s;
            beat_r <= 3'd0;
        end else if (wr_beat_s) begin
            beat_r <= beat_r + 3'd1;
        end else if (state_r == READ) begin
            beat_r <= rd_idx_s;
        end
    end

    // RAM port registers; rd_valid trails the issued read address by one edge to match RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_r         <= 1'b0;
            ram_di_r         <= '0;
            ram_write_addr_r <= '0;
            ram_read_addr_r  <= '0;
            rd_issue_r       <= 1'b0;
            rd_valid_r       <= 1'b0;
        end else begin
            ram_we_r   <= wr_beat_s;
            rd_issue_r <= (accept_s && !cmd_write) || (state_r == READ);
            rd_valid_r <= rd_issue_r;
            if (wr_beat_s) begin
                ram_di_r         <= wr_data;
                ram_write_addr_r <= wr_addr_s;
            end
            if ((accept_s && !cmd_write) || (state_r == READ)) begin
                ram_read_addr_r <= rd_addr_s;
            end
        end
    end

    assign cmd_ready      = (state_r == IDLE);
    assign busy           = (state_r != IDLE);
    assign wr_ready       = (state_r == WRITE);
    assign ram_we         = ram_we_r;
    assign ram_di         = ram_di_r;
    assign ram_write_addr = ram_write_addr_r;
    assign ram_read_addr  = ram_read_addr_r;
    assign rd_valid       = rd_valid_r;
    assign rd_data        = rd_valid_r ? ram_do : '0;

endmodule

// File: tb/tb_ddr3_burst_agen.sv
// Self-checking bench for ddr3_burst_agen: vector table, hand-written corner sequences, random bursts.
module tb_ddr3_burst_agen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_bank;
    logic [12:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        cmd_bc4, cmd_bt;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [35:0] ram_write_addr, ram_read_addr;
    logic [7:0]  ram_do = 8'h00;
    logic [7:0]  rd_data;
    logic        rd_valid, busy;

    ddr3_burst_agen #(.DATA_WIDTH(8), .ADDR_WIDTH(36)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_bc4(cmd_bc4), .cmd_bt(cmd_bt),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ram_di(ram_di), .ram_we(ram_we),
        .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
        .ram_do(ram_do), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef DDR3_BURST_INTERLEAVE_EN
    localparam logic ILV_EN = 1'b1;
`else
    localparam logic ILV_EN = 1'b0;
`endif

    typedef logic [7:0][9:0] cols_t;
    typedef logic [7:0][7:0] data_t;
    typedef struct packed {
        logic        wr;
        logic [2:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic        bc4;
        logic        bt;
        logic [7:0]  base;
        logic [7:0]  bub;
        cols_t       cols;
    } vec_t;

    vec_t        tbl [8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [43:0] wq [$];
    int          wcyc [$];
    logic [7:0]  rq [$];
    int          rcyc [$];
    logic [7:0]  mem [logic [35:0]];
    logic [7:0]  shadow [logic [35:0]];

    function automatic cols_t mkcols(input int c0, input int c1, input int c2, input int c3,
                                     input int c4, input int c5, input int c6, input int c7);
        cols_t r;
        r[0] = 10'(c0); r[1] = 10'(c1); r[2] = 10'(c2); r[3] = 10'(c3);
        r[4] = 10'(c4); r[5] = 10'(c5); r[6] = 10'(c6); r[7] = 10'(c7);
        return r;
    endfunction

    function automatic logic [35:0] mk_addr(input logic [2:0] bank, input logic [12:0] row,
                                            input logic [9:0] col);
        return {1'b0, bank, 3'b000, row, 6'b000000, col};
    endfunction

    // Reference beat ordering computed arithmetically from the DDR3 ordering rules.
    function automatic logic [9:0] model_col(input logic [9:0] col, input int k,
                                             input logic bc4, input logic bt);
        int c, kk, lo, hi;
        c  = int'(col);
        kk = bc4 ? (k % 4) : k;
        if (bt & ILV_EN) begin
            return 10'((c / 8) * 8 + ((c % 8) ^ kk));
        end
        lo = (c % 4 + kk % 4) % 4;
        hi = ((c / 4) % 2) ^ (kk / 4);
        return 10'((c / 8) * 8 + hi * 4 + lo);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM model: registered read, write on ram_we.
    always @(posedge clk) begin
        if (mem.exists(ram_read_addr)) ram_do <= mem[ram_read_addr];
        else ram_do <= 8'h00;
        if (ram_we) mem[ram_write_addr] = ram_di;
    end

    always @(negedge clk) begin
        if (ram_we) begin
            wq.push_back({ram_write_addr, ram_di});
            wcyc.push_back(cyc);
        end
        if (rd_valid) begin
            rq.push_back(rd_data);
            rcyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept_cmd(input logic wr, input logic [2:0] bank, input logic [12:0] row,
                              input logic [9:0] col, input logic bc4, input logic bt);
        int n;
        n = 0;
        cmd_write = wr; cmd_bank = bank; cmd_row = row; cmd_col = col;
        cmd_bc4 = bc4; cmd_bt = bt; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_write(input data_t wd, input logic [7:0] bub, input int n);
        int b, s;
        b = 0; s = 0;
        while (b < n && s < 32) begin
            wr_valid = (s < 8) ? ~bub[s] : 1'b1;
            wr_data  = wd[b];
            check("wr_ready", 64'(wr_ready), 64'd1);
            @(posedge clk); #1;
            if (wr_valid) b++;
            s++;
        end
        wr_valid = 1'b0;
    endtask

    task automatic run_burst(input logic wr, input logic [2:0] bank, input logic [12:0] row,
                             input logic [9:0] col, input logic bc4, input logic bt,
                             input data_t wd, input logic [7:0] bub, input cols_t cols,
                             input string tag);
        int n;
        logic [35:0] ea;
        logic [7:0]  ed;
        n = bc4 ? 4 : 8;
        wq.delete(); wcyc.delete(); rq.delete(); rcyc.delete();
        accept_cmd(wr, bank, row, col, bc4, bt);
        if (wr) begin
            drive_write(wd, bub, n);
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_wcnt"}, 64'(wq.size()), 64'(n));
            if (wcyc.size() == n)
                check({tag, "_wspan"}, 64'(wcyc[n-1] - wcyc[0]), 64'(n - 1 + $countones(bub)));
            for (int k = 0; k < n; k++) begin
                ea = mk_addr(bank, row, cols[k]);
                shadow[ea] = wd[k];
                if (k < wq.size()) begin
                    check({tag, "_waddr"}, 64'(wq[k][43:8]), 64'(ea));
                    check({tag, "_wdata"}, 64'(wq[k][7:0]), 64'(wd[k]));
                end
            end
        end else begin
            repeat (n + 3) @(posedge clk);
            #1;
            check({tag, "_rcnt"}, 64'(rq.size()), 64'(n));
            check({tag, "_no_we"}, 64'(wq.size()), 64'd0);
            for (int k = 0; k < n; k++) begin
                ea = mk_addr(bank, row, cols[k]);
                ed = shadow.exists(ea) ? shadow[ea] : 8'h00;
                if (k < rq.size()) begin
                    check({tag, "_rdata"}, 64'(rq[k]), 64'(ed));
                    check({tag, "_rcyc"}, 64'(rcyc[k]), 64'(acc_cyc + 1 + k));
                end
            end
        end
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_ready_end"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        data_t       wd;
        cols_t       cs;
        logic [2:0]  rb;
        logic [12:0] rr;
        logic [9:0]  rc;
        logic        rbc4, rbt;

        tbl[0] = '{1'b1, 3'd5, 13'h1ABC, 10'h3F5, 1'b0, 1'b0, 8'h10, 8'h00,
                   mkcols('h3F5, 'h3F6, 'h3F7, 'h3F4, 'h3F1, 'h3F2, 'h3F3, 'h3F0)};
        tbl[1] = tbl[0]; tbl[1].wr = 1'b0;
        tbl[2] = '{1'b1, 3'd2, 13'h0123, 10'h010, 1'b0, 1'b0, 8'h40, 8'b0010_0100,
                   mkcols('h010, 'h011, 'h012, 'h013, 'h014, 'h015, 'h016, 'h017)};
        tbl[3] = tbl[2]; tbl[3].wr = 1'b0; tbl[3].bub = 8'h00;
        tbl[4] = '{1'b1, 3'd3, 13'h0055, 10'h004, 1'b1, 1'b0, 8'h80, 8'h00,
                   mkcols('h004, 'h005, 'h006, 'h007, 0, 0, 0, 0)};
        tbl[5] = '{1'b0, 3'd3, 13'h0055, 10'h006, 1'b1, 1'b1, 8'h00, 8'h00,
                   mkcols('h006, 'h007, 'h004, 'h005, 0, 0, 0, 0)};
`ifdef DDR3_BURST_INTERLEAVE_EN
        tbl[6] = '{1'b1, 3'd4, 13'h0AAA, 10'h003, 1'b0, 1'b1, 8'hC0, 8'h00,
                   mkcols(3, 2, 1, 0, 7, 6, 5, 4)};
`else
        tbl[6] = '{1'b1, 3'd4, 13'h0AAA, 10'h003, 1'b0, 1'b1, 8'hC0, 8'h00,
                   mkcols(3, 0, 1, 2, 7, 4, 5, 6)};
`endif
        tbl[7] = tbl[6]; tbl[7].wr = 1'b0;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank = 3'd0; cmd_row = 13'd0;
        cmd_col = 10'd0; cmd_bc4 = 1'b0; cmd_bt = 1'b0; wr_data = 8'h00; wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_waddr", 64'(ram_write_addr), 64'd0);
        check("rst_raddr", 64'(ram_read_addr), 64'd0);
        check("rst_di", 64'(ram_di), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 8; k++) wd[k] = 8'(tbl[t].base + 8'(k));
            run_burst(tbl[t].wr, tbl[t].bank, tbl[t].row, tbl[t].col, tbl[t].bc4, tbl[t].bt,
                      wd, tbl[t].bub, tbl[t].cols, $sformatf("vec%0d", t));
        end

        // Write immediately followed by a read of the same burst.
        for (int k = 0; k < 8; k++) begin
            wd[k] = 8'hA0 + 8'(k);
            cs[k] = model_col(10'h3FF, k, 1'b0, 1'b0);
        end
        wq.delete(); rq.delete(); rcyc.delete();
        accept_cmd(1'b1, 3'd1, 13'h1FFF, 10'h3FF, 1'b0, 1'b0);
        drive_write(wd, 8'h00, 8);
        accept_cmd(1'b0, 3'd1, 13'h1FFF, 10'h3FF, 1'b0, 1'b0);
        check("b2b_we_at_capture", 64'(ram_we), 64'd0);
        repeat (11) @(posedge clk);
        #1;
        check("b2b_wcnt", 64'(wq.size()), 64'd8);
        check("b2b_rcnt", 64'(rq.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            shadow[mk_addr(3'd1, 13'h1FFF, cs[k])] = wd[k];
            if (k < rq.size()) begin
                check("b2b_rdata", 64'(rq[k]), 64'(wd[k]));
                check("b2b_rcyc", 64'(rcyc[k]), 64'(acc_cyc + 1 + k));
            end
        end

        // Reset while beat 3 of a write is being offered.
        accept_cmd(1'b1, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        wr_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wr_data = 8'(b);
            @(posedge clk); #1;
        end
        wr_data = 8'h33;
        #2 rst_n = 1'b0;
        #1;
        check("mw_ram_we", 64'(ram_we), 64'd0);
        check("mw_wr_ready", 64'(wr_ready), 64'd0);
        check("mw_busy", 64'(busy), 64'd0);
        wq.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mw_no_we_after", 64'(wq.size()), 64'd0);
        check("mw_cmd_ready", 64'(cmd_ready), 64'd1);
        wr_valid = 1'b0;
        for (int k = 0; k < 3; k++) shadow[mk_addr(3'd0, 13'd0, model_col(10'd0, k, 1'b0, 1'b0))] = 8'(k);

        // Reset in the middle of a read.
        accept_cmd(1'b0, 3'd5, 13'h1ABC, 10'h3F5, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 rq.delete();
        check("mr_busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mr_no_rd_after", 64'(rq.size()), 64'd0);

        for (int r = 0; r < 12; r++) begin
            rb   = 3'($urandom);
            rr   = 13'($urandom);
            rc   = 10'($urandom);
            rbc4 = 1'($urandom);
            rbt  = 1'($urandom);
            for (int k = 0; k < 8; k++) begin
                wd[k] = 8'($urandom);
                cs[k] = model_col(rc, k, rbc4, rbt);
            end
            run_burst(1'b1, rb, rr, rc, rbc4, rbt, wd, 8'h00, cs, "rnd_w");
            run_burst(1'b0, rb, rr, rc, rbc4, rbt, wd, 8'h00, cs, "rnd_r");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
